// File: rtl/fft_twiddle_sched_if.sv
// Butterfly-issue bus from the twiddle scheduler to the radix-2 butterfly datapath.
// The scheduler drives the operand addresses and twiddle pair; the datapath drives out_ready.
interface fft_twiddle_sched_if #(
    parameter int N        = 16,
    parameter int NPT_LOG2 = 5
);
    logic                  out_valid;
    logic                  out_ready;
    logic [NPT_LOG2-1:0]   addr_a;
    logic [NPT_LOG2-1:0]   addr_b;
    logic [NPT_LOG2-2:0]   tw_idx;
    logic [N-1:0]          tw_re;
    logic [N-1:0]          tw_im;
    logic [2:0]            stage;

    modport master (
        output out_valid, addr_a, addr_b, tw_idx, tw_re, tw_im, stage,
        input  out_ready
    );

    modport slave (
        input  out_valid, addr_a, addr_b, tw_idx, tw_re, tw_im, stage,
        output out_ready
    );
endinterface

// File: rtl/fft_twiddle_sched.sv
// In-place radix-2 DIT butterfly scheduler: walks all stages/butterflies and issues (a, b, W^k).
// Optional macro FFT_INVERSE_EN adds an inv input that conjugates the twiddle for the inverse FFT.
module fft_twiddle_sched #(
    parameter int N        = 16,
    parameter int NPT_LOG2 = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [(2**(NPT_LOG2-1))*N-1:0]      tw_re_in,
    input  logic [(2**(NPT_LOG2-1))*N-1:0]      tw_im_in,
`ifdef FFT_INVERSE_EN
    input  logic                                inv,
`endif
    output logic                                busy,
    output logic                                done,
    fft_twiddle_sched_if.master                 bus
);
    localparam int              AW     = NPT_LOG2;
    localparam int              IW     = NPT_LOG2 - 1;
    localparam logic [2:0]      S_LAST = 3'(NPT_LOG2 - 1);
    localparam logic [IW-1:0]   J_LAST = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      s_q, sel_s;
    logic [IW-1:0]   j_q, sel_j;
    logic            load, xfer, last;

    logic [AW-1:0]   half, p_w, g_w, a_w, b_w;
    logic [IW-1:0]   k_w;
    logic [N-1:0]    re_sel, im_sel, im_fin;

    assign xfer = bus.out_valid & bus.out_ready;
    assign last = (s_q == S_LAST) && (j_q == J_LAST);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sel_s     = s_q;
        sel_j     = j_q;
        case (state)
            IDLE: if (start) begin
                state_nxt = RUN;
                load      = 1'b1;
                sel_s     = '0;
                sel_j     = '0;
            end
            RUN: if (xfer) begin
                if (last) begin
                    state_nxt = DONE;
                end else begin
                    load  = 1'b1;
                    sel_j = j_q + 1'b1;
                    if (j_q == J_LAST) sel_s = s_q + 3'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address math for the butterfly being loaded next: group g, position p within the group.
    always_comb begin
        half   = AW'(1) << sel_s;
        p_w    = AW'(sel_j) & (half - AW'(1));
        g_w    = AW'(sel_j >> sel_s);
        a_w    = (g_w << (sel_s + 3'd1)) + p_w;
        b_w    = a_w + half;
        k_w    = IW'(p_w << (3'(IW) - sel_s));
        re_sel = tw_re_in[k_w*N +: N];
        im_sel = tw_im_in[k_w*N +: N];
    end

`ifdef FFT_INVERSE_EN
    logic inv_q, inv_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         inv_q <= 1'b0;
        else if (state == IDLE && start) inv_q <= inv;
    end

    // The first butterfly is loaded on the same edge that latches inv, so bypass the register then.
    assign inv_sel = (state == IDLE) ? inv : inv_q;
    assign im_fin  = inv_sel ? -im_sel : im_sel;
`else
    assign im_fin  = im_sel;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q           <= '0;
            j_q           <= '0;
            bus.out_valid <= 1'b0;
            bus.addr_a    <= '0;
            bus.addr_b    <= '0;
            bus.tw_idx    <= '0;
            bus.tw_re     <= '0;
            bus.tw_im     <= '0;
            bus.stage     <= '0;
        end else if (load) begin
            s_q           <= sel_s;
            j_q           <= sel_j;
            bus.out_valid <= 1'b1;
            bus.addr_a    <= a_w;
            bus.addr_b    <= b_w;
            bus.tw_idx    <= k_w;
            bus.tw_re     <= re_sel;
            bus.tw_im     <= im_fin;
            bus.stage     <= sel_s;
        end else if (xfer && last) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_twiddle_sched.sv
// Directed self-checking bench for fft_twiddle_sched: full schedules, stall, start pokes, reset abort.
// Expected butterflies come from a group/position enumeration of the DIT schedule built here.
module tb_fft_twiddle_sched;
    localparam int N = 16;
`ifdef FFT_INVERSE_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            inv;
    logic [16*N-1:0] tw_re_in, tw_im_in;
    logic            busy, done;

    fft_twiddle_sched_if #(.N(N), .NPT_LOG2(5)) bus ();

    fft_twiddle_sched #(.N(N), .NPT_LOG2(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tw_re_in (tw_re_in),
        .tw_im_in (tw_im_in),
`ifdef FFT_INVERSE_EN
        .inv      (inv),
`endif
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] rom_re [16];
    logic [15:0] rom_im [16];
    int exp_s [80];
    int exp_a [80];
    int exp_b [80];
    int exp_k [80];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] obs_pack();
        return {12'b0, bus.out_valid, busy, done, bus.stage, bus.addr_a, bus.addr_b,
                bus.tw_idx, bus.tw_re, bus.tw_im};
    endfunction

    function automatic logic [63:0] exp_pack(input int i, input bit inv_l);
        logic [15:0] im;
        im = rom_im[exp_k[i]];
        if (INV_EN && inv_l) im = -im;
        return {12'b0, 3'b110, 3'(exp_s[i]), 5'(exp_a[i]), 5'(exp_b[i]), 4'(exp_k[i]),
                rom_re[exp_k[i]], im};
    endfunction

    task automatic set_rom(input bit scramble);
        for (int k = 0; k < 16; k++) begin
            tw_re_in[k*N +: N] = scramble ? ~rom_re[k] : rom_re[k];
            tw_im_in[k*N +: N] = scramble ? ~rom_im[k] : rom_im[k];
        end
    endtask

    // Starts at a negedge in IDLE; returns at a negedge in IDLE after the done pulse.
    task automatic run_schedule(input int stall_idx, input bit poke, input bit inv_l);
        int          idx       = 0;
        int          done_cnt  = 0;
        int          stall_cnt = 0;
        bit          fin       = 1'b0;
        logic [63:0] snap      = '0;
        inv           = inv_l;
        bus.out_ready = 1'b1;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("latency", {62'b0, bus.out_valid, busy}, 64'd3);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            start = 1'b0;
            if (done) begin
                done_cnt++;
                if (poke) start = 1'b1;
            end else if (done_cnt > 0) begin
                check("idle_after_done", {61'b0, busy, bus.out_valid, done}, 64'd0);
                fin = 1'b1;
            end
            if (poke && idx == 40) start = 1'b1;
            bus.out_ready = 1'b1;
            if (idx == stall_idx && stall_cnt < 4) begin
                if (stall_cnt == 0) snap = obs_pack();
                else                check("stall_hold", obs_pack(), snap);
                if (stall_cnt < 3) bus.out_ready = 1'b0;
                set_rom(stall_cnt < 3);
                stall_cnt++;
            end
            if (bus.out_valid && bus.out_ready && !fin) begin
                if (idx < 80) check($sformatf("bfly%0d", idx), obs_pack(), exp_pack(idx, inv_l));
                if (idx == 37)
                    check("s2j5", {50'b0, bus.addr_a, bus.addr_b, bus.tw_idx}, {50'b0, 5'd9, 5'd13, 4'd4});
                if (idx == 79)
                    check("s4j15", {34'b0, bus.addr_a, bus.addr_b, bus.tw_idx, bus.tw_im},
                          {34'b0, 5'd15, 5'd31, 4'd15, (inv_l && INV_EN) ? 16'hFFF8 : 16'h0008});
                if (INV_EN && idx >= 64 && bus.tw_idx == 4'd1)
                    check("conj_k1", {32'b0, bus.tw_re, bus.tw_im},
                          {32'b0, rom_re[1], inv_l ? 16'hFFFC : 16'h0004});
                idx++;
            end
            if (!fin) @(negedge clk);
        end
        start = 1'b0;
        check("timeout", 64'(fin), 64'd1);
        check("xfers", 64'(idx), 64'd80);
        check("done_pulses", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int n = 0;
        int done_seen = 0;
        for (int k = 0; k < 16; k++) begin
            rom_re[k] = 16'h1000 + 16'(k);
            rom_im[k] = 16'h0100 * 16'(k);
        end
        rom_im[0]  = 16'h8000;
        rom_im[1]  = 16'h0004;
        rom_im[15] = 16'h0008;
        for (int s = 0; s < 5; s++) begin
            for (int g = 0; g < (16 >> s); g++) begin
                for (int p = 0; p < (1 << s); p++) begin
                    exp_s[n] = s;
                    exp_a[n] = g * 2 * (1 << s) + p;
                    exp_b[n] = exp_a[n] + (1 << s);
                    exp_k[n] = p * (16 >> s);
                    n++;
                end
            end
        end

        rst           = 1'b1;
        start         = 1'b0;
        inv           = 1'b0;
        bus.out_ready = 1'b0;
        set_rom(1'b0);
        #1;
        check("reset_state", obs_pack(), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_schedule(-1, 1'b0, 1'b0);
        run_schedule(20, 1'b0, 1'b0);
        run_schedule(-1, 1'b1, 1'b0);

        // Abort at stage 3, j=7 and confirm the asynchronous clear with no done pulse.
        bus.out_ready = 1'b1;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (55) @(negedge clk);
        check("s3j7_before_rst", obs_pack(), exp_pack(55, 1'b0));
        #2 rst = 1'b1;
        #1 check("rst_async", obs_pack(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("no_done_after_rst", 64'(done_seen), 64'd0);
        run_schedule(-1, 1'b0, 1'b0);

`ifdef FFT_INVERSE_EN
        run_schedule(-1, 1'b0, 1'b1);
        run_schedule(-1, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
